// File: rtl/config_pkg.sv
// Shared definitions for the cartridge configuration register block: register
// indices, CTRL bit positions, reset values, lock magic and write-mask helpers.
package config_pkg;

    typedef enum logic [2:0] {
        REG_CTRL        = 3'd0,
        REG_DD_OFFSET   = 3'd1,
        REG_SAVE_OFFSET = 3'd2,
        REG_STATUS      = 3'd3,
        REG_LOCK        = 3'd4
    } reg_idx_e;

    localparam int CTRL_SWITCH      = 0;
    localparam int CTRL_WRITABLE    = 1;
    localparam int CTRL_DD_EN       = 2;
    localparam int CTRL_SRAM_EN     = 3;
    localparam int CTRL_FLASHRAM_EN = 4;
    localparam int CTRL_READ_MODE   = 5;

    localparam int NUM_CFG_REGS         = 3;
    localparam int OFFSET_ALIGN_DEFAULT = 17;

    localparam logic [31:0] RST_CTRL        = 32'h0000_003C;
    localparam logic [31:0] RST_DD_OFFSET   = 32'h03BE_0000;
    localparam logic [31:0] RST_SAVE_OFFSET = 32'h03FE_0000;
    localparam logic [31:0] CTRL_RW_MASK    = 32'h0000_003F;
    localparam logic [31:0] LOCK_MAGIC      = 32'h4C4F_434B;

    // Writable bits of an offset register: [25:align].
    function automatic logic [31:0] offset_rw_mask(input int unsigned align);
        logic [31:0] m;
        for (int unsigned i = 0; i < 32; i++) begin
            m[i] = (i >= align) && (i < 32'd26);
        end
        return m;
    endfunction

    function automatic logic [31:0] apply_wmask(input logic [31:0] old_val,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wmask);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = wmask[b] ? wdata[b*8 +: 8] : old_val[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/config_regs_if.sv
// MCU-side register bus for config_regs: one-cycle request strobe, ack one cycle later.
interface config_regs_if;
    logic        bus_request;
    logic        bus_write;
    logic [2:0]  bus_address;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wmask;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_request, bus_write, bus_address, bus_wdata, bus_wmask,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_request, bus_write, bus_address, bus_wdata, bus_wmask,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/config_regs.sv
// Shadow/live cartridge configuration registers with atomic commit while the PI is idle.
// Optional write lock is built when CONFIG_WRITE_LOCK_EN is defined.
module config_regs
    import config_pkg::*;
#(
    parameter int OFFSET_ALIGN = OFFSET_ALIGN_DEFAULT
) (
    input  logic         clk,
    input  logic         reset_n,
    config_regs_if.slave bus,
    input  logic         pi_busy,
    output logic         sdram_switch,
    output logic         sdram_writable,
    output logic         dd_enabled,
    output logic         sram_enabled,
    output logic         flashram_enabled,
    output logic         flashram_read_mode,
    output logic [25:0]  dd_offset,
    output logic [25:0]  save_offset,
    output logic         cfg_changed
);

    localparam logic [31:0] OFFSET_MASK = offset_rw_mask(OFFSET_ALIGN);

    logic [31:0] shadow_q [NUM_CFG_REGS];
    logic [31:0] shadow_d [NUM_CFG_REGS];
    logic [31:0] live_q   [NUM_CFG_REGS];
    logic        pending_q;
    logic        pending_d;
    logic        ack_q;
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;
    logic        cfg_changed_q;
    logic        wr_s;
    logic        copy_s;
    logic        commit_req_s;
    logic        lock_s;

`ifdef CONFIG_WRITE_LOCK_EN
    logic lock_q;
    logic lock_set_s;
`endif

    assign wr_s   = bus.bus_request & bus.bus_write;
    assign copy_s = pending_q & ~pi_busy;
    // A commit landing on a copy edge is absorbed by that copy.
    assign pending_d = copy_s ? 1'b0 : (pending_q | commit_req_s);

    // Write decode: shadow is frozen while a commit is pending or the block is locked.
    always_comb begin
        shadow_d     = shadow_q;
        commit_req_s = 1'b0;
`ifdef CONFIG_WRITE_LOCK_EN
        lock_set_s   = 1'b0;
`endif
        if (wr_s && !lock_s) begin
            case (bus.bus_address)
                REG_CTRL: begin
                    if (!pending_q) shadow_d[0] = apply_wmask(shadow_q[0], bus.bus_wdata, bus.bus_wmask) & CTRL_RW_MASK;
                    else            shadow_d[0] = shadow_q[0];
                end
                REG_DD_OFFSET: begin
                    if (!pending_q) shadow_d[1] = apply_wmask(shadow_q[1], bus.bus_wdata, bus.bus_wmask) & OFFSET_MASK;
                    else            shadow_d[1] = shadow_q[1];
                end
                REG_SAVE_OFFSET: begin
                    if (!pending_q) shadow_d[2] = apply_wmask(shadow_q[2], bus.bus_wdata, bus.bus_wmask) & OFFSET_MASK;
                    else            shadow_d[2] = shadow_q[2];
                end
                REG_STATUS: commit_req_s = bus.bus_wmask[0] & bus.bus_wdata[0];
`ifdef CONFIG_WRITE_LOCK_EN
                REG_LOCK: lock_set_s = (bus.bus_wdata == LOCK_MAGIC) && (bus.bus_wmask == 4'hF);
`endif
                default: commit_req_s = 1'b0;
            endcase
        end else begin
            commit_req_s = 1'b0;
        end
    end

    // Read mux: data is captured with the request and presented alongside ack.
    always_comb begin
        rdata_d = 32'd0;
        if (bus.bus_request && !bus.bus_write) begin
            case (bus.bus_address)
                REG_CTRL:        rdata_d = shadow_q[0];
                REG_DD_OFFSET:   rdata_d = shadow_q[1];
                REG_SAVE_OFFSET: rdata_d = shadow_q[2];
                REG_STATUS:      rdata_d = {30'd0, lock_s, pending_q};
`ifdef CONFIG_WRITE_LOCK_EN
                REG_LOCK:        rdata_d = {31'd0, lock_s};
`endif
                default:         rdata_d = 32'd0;
            endcase
        end else begin
            rdata_d = 32'd0;
        end
    end

    // Bus response, shadow/live state and commit pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_q         <= 1'b0;
            rdata_q       <= 32'd0;
            pending_q     <= 1'b0;
            cfg_changed_q <= 1'b0;
            shadow_q[0]   <= RST_CTRL;
            shadow_q[1]   <= RST_DD_OFFSET;
            shadow_q[2]   <= RST_SAVE_OFFSET;
            live_q[0]     <= RST_CTRL;
            live_q[1]     <= RST_DD_OFFSET;
            live_q[2]     <= RST_SAVE_OFFSET;
        end else begin
            ack_q         <= bus.bus_request;
            rdata_q       <= rdata_d;
            pending_q     <= pending_d;
            cfg_changed_q <= copy_s;
            shadow_q      <= shadow_d;
            if (copy_s) live_q <= shadow_q;
            else        live_q <= live_q;
        end
    end

`ifdef CONFIG_WRITE_LOCK_EN
    // Lock is sticky; only reset clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)        lock_q <= 1'b0;
        else if (lock_set_s) lock_q <= 1'b1;
        else                 lock_q <= lock_q;
    end
    assign lock_s = lock_q;
`else
    assign lock_s = 1'b0;
`endif

    assign bus.bus_ack   = ack_q;
    assign bus.bus_rdata = rdata_q;

    assign sdram_switch       = live_q[0][CTRL_SWITCH];
    assign sdram_writable     = live_q[0][CTRL_WRITABLE];
    assign dd_enabled         = live_q[0][CTRL_DD_EN];
    assign sram_enabled       = live_q[0][CTRL_SRAM_EN];
    assign flashram_enabled   = live_q[0][CTRL_FLASHRAM_EN];
    assign flashram_read_mode = live_q[0][CTRL_READ_MODE];
    assign dd_offset          = live_q[1][25:0];
    assign save_offset        = live_q[2][25:0];
    assign cfg_changed        = cfg_changed_q;

    logic unused_live_s;
    assign unused_live_s = ^{live_q[0][31:6], live_q[1][31:26], live_q[2][31:26]};

endmodule

// File: tb/tb_config_regs.sv
// Randomized bench for config_regs against a register-map level reference model.
module tb_config_regs;

    localparam logic [31:0] MAGIC = 32'h4C4F_434B;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pi_busy;
    logic        sdram_switch, sdram_writable, dd_enabled, sram_enabled;
    logic        flashram_enabled, flashram_read_mode, cfg_changed;
    logic [25:0] dd_offset, save_offset;

    config_regs_if bus_if ();

    config_regs dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .bus                (bus_if),
        .pi_busy            (pi_busy),
        .sdram_switch       (sdram_switch),
        .sdram_writable     (sdram_writable),
        .dd_enabled         (dd_enabled),
        .sram_enabled       (sram_enabled),
        .flashram_enabled   (flashram_enabled),
        .flashram_read_mode (flashram_read_mode),
        .dd_offset          (dd_offset),
        .save_offset        (save_offset),
        .cfg_changed        (cfg_changed)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int mis_cnt = 0;

    // Reference model: register contents as the MCU sees them.
    logic [31:0] m_sh [3];
    logic [31:0] m_lv [3];
    bit          m_pend;
    bit          m_lock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            mis_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] writable_bits(input int a);
        return (a == 0) ? 32'h0000_003F : 32'h03FE_0000;
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return m_sh[0];
            3'd1:    return m_sh[1];
            3'd2:    return m_sh[2];
            3'd3:    return {30'd0, m_lock, m_pend};
`ifdef CONFIG_WRITE_LOCK_EN
            3'd4:    return {31'd0, m_lock};
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [63:0] dut_live();
        return {6'd0, sdram_switch, sdram_writable, dd_enabled, sram_enabled,
                flashram_enabled, flashram_read_mode, dd_offset, save_offset};
    endfunction

    function automatic logic [63:0] model_live();
        return {6'd0, m_lv[0][0], m_lv[0][1], m_lv[0][2], m_lv[0][3], m_lv[0][4], m_lv[0][5],
                m_lv[1][25:0], m_lv[2][25:0]};
    endfunction

    task automatic model_reset();
        m_sh[0] = 32'h0000_003C; m_sh[1] = 32'h03BE_0000; m_sh[2] = 32'h03FE_0000;
        m_lv[0] = 32'h0000_003C; m_lv[1] = 32'h03BE_0000; m_lv[2] = 32'h03FE_0000;
        m_pend = 1'b0;
        m_lock = 1'b0;
    endtask

    task automatic idle_inputs();
        bus_if.bus_request = 1'b0;
        bus_if.bus_write   = 1'b0;
        bus_if.bus_address = 3'd0;
        bus_if.bus_wdata   = 32'd0;
        bus_if.bus_wmask   = 4'd0;
    endtask

    task automatic do_reset();
        logic [63:0] rst_live;
        rst_live = {6'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 26'h3BE_0000, 26'h3FE_0000};
        idle_inputs();
        pi_busy = 1'b0;
        reset_n = 1'b0;
        #2;
        model_reset();
        check("rst_ack", bus_if.bus_ack, 1'b0);
        check("rst_rdata", bus_if.bus_rdata, 32'd0);
        check("rst_cfg_changed", cfg_changed, 1'b0);
        check("rst_live", dut_live(), rst_live);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One clock: apply a bus access, advance the model by one edge, compare everything.
    task automatic cyc(input logic rq, input logic w, input logic [2:0] a,
                       input logic [31:0] d, input logic [3:0] m);
        logic [31:0] exp_rd;
        logic [31:0] merged;
        bit          copy;
        bit          commit;
        bus_if.bus_request = rq;
        bus_if.bus_write   = w;
        bus_if.bus_address = a;
        bus_if.bus_wdata   = d;
        bus_if.bus_wmask   = m;
        exp_rd = (rq && !w) ? m_read(a) : 32'd0;
        copy   = m_pend && !pi_busy;
        commit = 1'b0;
        @(posedge clk);
        if (copy) begin
            for (int i = 0; i < 3; i++) m_lv[i] = m_sh[i];
        end
        if (rq && w && !m_lock) begin
            if (a <= 3'd2 && !m_pend) begin
                merged = m_sh[a];
                for (int b = 0; b < 4; b++) begin
                    if (m[b]) merged[b*8 +: 8] = d[b*8 +: 8];
                end
                m_sh[a] = merged & writable_bits(int'(a));
            end else if (a == 3'd3) begin
                commit = m[0] && d[0];
            end
`ifdef CONFIG_WRITE_LOCK_EN
            else if (a == 3'd4 && d == MAGIC && m == 4'hF) begin
                m_lock = 1'b1;
            end
`endif
        end
        m_pend = copy ? 1'b0 : (m_pend || commit);
        #1;
        check("ack", bus_if.bus_ack, rq);
        check("rdata", bus_if.bus_rdata, exp_rd);
        check("cfg_changed", cfg_changed, copy);
        check("live", dut_live(), model_live());
        idle_inputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
    endtask

    task automatic rd(input logic [2:0] a);
        cyc(1'b1, 1'b0, a, 32'd0, 4'd0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cyc(1'b1, 1'b1, a, d, 4'hF);
    endtask

    initial begin
        idle_inputs();
        pi_busy = 1'b0;
        reset_n = 1'b0;
        model_reset();
        #7;
        do_reset();

        // Reset readback
        rd(3'd0); check("t1_ctrl", bus_if.bus_rdata, 32'h0000_003C);
        rd(3'd1); check("t1_dd", bus_if.bus_rdata, 32'h03BE_0000);
        rd(3'd2); check("t1_save", bus_if.bus_rdata, 32'h03FE_0000);
        rd(3'd3); check("t1_status", bus_if.bus_rdata, 32'd0);

        // Basic commit
        wr(3'd0, 32'h0000_0003);
        wr(3'd1, 32'h01FF_FFFF);
        rd(3'd1); check("t2_dd_read", bus_if.bus_rdata, 32'h01FE_0000);
        wr(3'd3, 32'd1);
        idle(4);
        check("t2_dd_live", dd_offset, 26'h1FE_0000);
        check("t2_switch", sdram_switch, 1'b1);
        check("t2_dd_en", dd_enabled, 1'b0);

        // Commit held off by a busy PI
        pi_busy = 1'b1;
        wr(3'd0, 32'h0000_0020);
        wr(3'd3, 32'd1);
        idle(20);
        check("t3_live_held", flashram_read_mode, 1'b0);
        rd(3'd3); check("t3_status_pend", bus_if.bus_rdata, 32'd1);
        // Shadow frozen while pending
        wr(3'd2, 32'd0);
        pi_busy = 1'b0;
        idle(2);
        rd(3'd3); check("t3_status_clear", bus_if.bus_rdata, 32'd0);
        check("t4_save_kept", save_offset, 26'h3FE_0000);
        check("t3_read_mode", flashram_read_mode, 1'b1);

        // Byte masking on CTRL and back-to-back reads
        do_reset();
        cyc(1'b1, 1'b1, 3'd0, 32'hFFFF_FFFF, 4'b0010);
        rd(3'd0); check("t5_ctrl0", bus_if.bus_rdata, 32'h0000_003C);
        rd(3'd0); check("t5_ctrl1", bus_if.bus_rdata, 32'h0000_003C);
        rd(3'd0);
        wr(3'd7, 32'hFFFF_FFFF);
        rd(3'd7); check("t5_reserved", bus_if.bus_rdata, 32'd0);

`ifdef CONFIG_WRITE_LOCK_EN
        do_reset();
        wr(3'd4, MAGIC);
        wr(3'd0, 32'd0);
        wr(3'd3, 32'd1);
        idle(3);
        rd(3'd0); check("t6_ctrl", bus_if.bus_rdata, 32'h0000_003C);
        rd(3'd3); check("t6_status", bus_if.bus_rdata, 32'd2);
        rd(3'd4); check("t6_lock", bus_if.bus_rdata, 32'd1);
        do_reset();
        rd(3'd3); check("t6_unlock", bus_if.bus_rdata, 32'd0);
`endif

        // Reset in the middle of an access: no ack afterwards
        bus_if.bus_request = 1'b1;
        bus_if.bus_write   = 1'b0;
        bus_if.bus_address = 3'd0;
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_reset_ack", bus_if.bus_ack, 1'b0);
        do_reset();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic        rq, w;
            logic [2:0]  a;
            logic [31:0] d;
            logic [3:0]  m;
            if ($urandom_range(0, 3) == 0) pi_busy = ~pi_busy;
            rq = ($urandom_range(0, 3) != 0);
            w  = $urandom_range(0, 1);
            a  = 3'($urandom_range(0, 7));
            d  = $urandom;
            m  = 4'($urandom_range(0, 15));
            if (a == 3'd3 && $urandom_range(0, 1) == 1) begin
                d[0] = 1'b1;
                m[0] = 1'b1;
            end
            if (a == 3'd4 && $urandom_range(0, 15) == 0) begin
                d = MAGIC;
                m = 4'hF;
            end
            cyc(rq, w, a, d, m);
            if ($urandom_range(0, 199) == 0) do_reset();
        end

        pi_busy = 1'b0;
        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
        $finish;
    end

endmodule
